// File: rtl/game_pkg.sv
// Shared types for the counter-game command path: op codes, driver states, command record.
package game_pkg;

  localparam int SIZE  = 4;
  localparam int REP_W = 4;

  typedef enum logic [1:0] {
    OP_INC1 = 2'b00,
    OP_INC2 = 2'b01,
    OP_DEC1 = 2'b10,
    OP_DEC2 = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    FLUSH = 2'd2
  } drv_state_e;

  typedef struct packed {
    logic             load;
    op_e              op;
    logic [SIZE-1:0]  value;
    logic [REP_W-1:0] reps;
  } game_cmd_t;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Generic FIFO, wrap-bit pointers, head visible combinationally; push ignored when full.
// Synchronous flush empties it at the edge and takes priority over push/pop.
module cmd_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  T                       push_dat,
  input  logic                   pop,
  input  logic                   flush,
  output T                       head_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  T           mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        do_push, do_pop;

  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign count    = wr_q - rd_q;
  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_dat = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/game_cmd_driver.sv
// Replays queued host moves onto the counter pins; first outputs one edge after accept, no gaps.
// cmd_ready falls when the queue is full or while waiting out a game-over flush.
module game_cmd_driver
  import game_pkg::*;
#(
  parameter int SIZE  = game_pkg::SIZE,
  parameter int DEPTH = 4,
  parameter int REP_W = game_pkg::REP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [1:0]       cmd_op,
  input  logic [SIZE-1:0]  cmd_value,
  input  logic [REP_W-1:0] cmd_reps,
  input  logic             GAMEOVER,
  input  logic             game_reset,
  output logic [1:0]       control,
  output logic             INIT_c,
  output logic [SIZE-1:0]  INIT_l,
  output logic             busy,
  output logic [7:0]       dropped
);

  localparam int CW = $clog2(DEPTH) + 1;

  drv_state_e       state_q, state_d;
  logic             seen_rst_q, seen_rst_d;
  game_cmd_t        push_dat, head_dat;
  logic             pop, flush, fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_cnt;
  logic             hs, cmd_done;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [1:0]       control_q, control_d;
  logic             init_c_q, init_c_d;
  logic [SIZE-1:0]  init_l_q, init_l_d;
  logic             busy_q, busy_d;
  logic [7:0]       dropped_q, dropped_d;

  assign cmd_ready = !fifo_full && (state_q != FLUSH);
  assign hs        = cmd_valid && cmd_ready;
  assign push_dat  = '{load: cmd_load, op: op_e'(cmd_op), value: cmd_value, reps: cmd_reps};
  assign cmd_done  = (rep_q == '0);

  cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (game_cmd_t)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (hs),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (flush),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      seen_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      seen_rst_q <= seen_rst_d;
    end
  end

  // FLUSH exits only after game_reset has been seen high and then low.
  always_comb begin
    state_d    = state_q;
    seen_rst_d = seen_rst_q;
    unique case (state_q)
      IDLE: begin
        if (GAMEOVER)         state_d = FLUSH;
        else if (!fifo_empty) state_d = APPLY;
      end
      APPLY: begin
        if (GAMEOVER)                    state_d = FLUSH;
        else if (cmd_done && fifo_empty) state_d = IDLE;
      end
      FLUSH: begin
        if (game_reset) begin
          seen_rst_d = 1'b1;
        end else if (seen_rst_q) begin
          seen_rst_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    control_d = control_q;
    init_c_d  = init_c_q;
    init_l_d  = init_l_q;
    busy_d    = busy_q;
    rep_d     = rep_q;
    dropped_d = dropped_q;
    pop       = 1'b0;
    flush     = 1'b0;
    unique case (state_q)
      IDLE, APPLY: begin
        if (GAMEOVER) begin
          flush     = 1'b1;
          init_c_d  = 1'b0;
          busy_d    = 1'b0;
          dropped_d = sat_add8(dropped_q,
                               8'(fifo_cnt) + 8'(state_q == APPLY) + 8'(hs));
        end else if (state_q == IDLE || cmd_done) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            busy_d    = 1'b1;
            control_d = head_dat.op;
            init_c_d  = head_dat.load;
            init_l_d  = head_dat.load ? head_dat.value : init_l_q;
            rep_d     = head_dat.load ? '0 : head_dat.reps;
          end else begin
            busy_d   = 1'b0;
            init_c_d = 1'b0;
          end
        end else begin
          rep_d = rep_q - 1'b1;
        end
      end
      default: begin
        init_c_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      control_q <= 2'b00;
      init_c_q  <= 1'b0;
      init_l_q  <= '0;
      busy_q    <= 1'b0;
      rep_q     <= '0;
      dropped_q <= 8'd0;
    end else begin
      control_q <= control_d;
      init_c_q  <= init_c_d;
      init_l_q  <= init_l_d;
      busy_q    <= busy_d;
      rep_q     <= rep_d;
      dropped_q <= dropped_d;
    end
  end

  assign control = control_q;
  assign INIT_c  = init_c_q;
  assign INIT_l  = init_l_q;
  assign busy    = busy_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_game_cmd_driver.sv
// Directed vector bench for game_cmd_driver: table of per-cycle stimulus plus flush/reset sequences.
module tb_game_cmd_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_load;
  logic [1:0] cmd_op;
  logic [3:0] cmd_value, cmd_reps;
  logic       GAMEOVER, game_reset;
  logic [1:0] control;
  logic       INIT_c, busy;
  logic [3:0] INIT_l;
  logic [7:0] dropped;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  game_cmd_driver #(.SIZE(4), .DEPTH(4), .REP_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_load   (cmd_load),
    .cmd_op     (cmd_op),
    .cmd_value  (cmd_value),
    .cmd_reps   (cmd_reps),
    .GAMEOVER   (GAMEOVER),
    .game_reset (game_reset),
    .control    (control),
    .INIT_c     (INIT_c),
    .INIT_l     (INIT_l),
    .busy       (busy),
    .dropped    (dropped)
  );

  typedef struct {
    logic        vld;
    logic        ld;
    logic [1:0]  op;
    logic [3:0]  val;
    logic [3:0]  reps;
    logic        go;
    logic        gr;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [16:0] pk(input logic rdy, input logic bsy, input logic ic,
                                     input logic [1:0] ctl, input logic [3:0] il,
                                     input logic [7:0] d);
    return {rdy, bsy, ic, ctl, il, d};
  endfunction

  function automatic vec_t mk(input logic vld, input logic ld, input logic [1:0] op,
                              input logic [3:0] val, input logic [3:0] reps,
                              input logic go, input logic gr, input logic [16:0] exp);
    vec_t v;
    v.vld = vld; v.ld = ld; v.op = op; v.val = val; v.reps = reps;
    v.go = go; v.gr = gr; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [16:0] exp);
    logic [16:0] act;
    act = {cmd_ready, busy, INIT_c, control, INIT_l, dropped};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s rdy/busy/initc/ctl/initl/drop got %b/%b/%b/%b/%h/%0d want %b/%b/%b/%b/%h/%0d",
               nm, act[16], act[15], act[14], act[13:12], act[11:8], act[7:0],
               exp[16], exp[15], exp[14], exp[13:12], exp[11:8], exp[7:0]);
    end
  endtask

  // Inputs are held across one rising edge; outputs are sampled 1 time unit later.
  task automatic step(input logic vld, input logic ld, input logic [1:0] op,
                      input logic [3:0] val, input logic [3:0] reps,
                      input logic go, input logic gr);
    cmd_valid = vld; cmd_load = ld; cmd_op = op; cmd_value = val; cmd_reps = reps;
    GAMEOVER = go; game_reset = gr;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; GAMEOVER = 1'b0; game_reset = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_drop;

    // Counting command op=01 reps=2, then load A followed by count op=10 reps=0.
    tbl.push_back(mk(1, 0, 2'b01, 4'h0, 4'd2, 0, 0, pk(1, 0, 0, 2'b00, 4'h0, 0)));
    tbl.push_back(mk(0, 0, 2'b00, 4'h0, 4'd0, 0, 0, pk(1, 1, 0, 2'b01, 4'h0, 0)));
    tbl.push_back(mk(0, 0, 2'b00, 4'h0, 4'd0, 0, 0, pk(1, 1, 0, 2'b01, 4'h0, 0)));
    tbl.push_back(mk(0, 0, 2'b00, 4'h0, 4'd0, 0, 0, pk(1, 1, 0, 2'b01, 4'h0, 0)));
    tbl.push_back(mk(0, 0, 2'b00, 4'h0, 4'd0, 0, 0, pk(1, 0, 0, 2'b01, 4'h0, 0)));
    tbl.push_back(mk(1, 1, 2'b00, 4'hA, 4'd7, 0, 0, pk(1, 0, 0, 2'b01, 4'h0, 0)));
    tbl.push_back(mk(1, 0, 2'b10, 4'h0, 4'd0, 0, 0, pk(1, 1, 1, 2'b00, 4'hA, 0)));
    tbl.push_back(mk(0, 0, 2'b00, 4'h0, 4'd0, 0, 0, pk(1, 1, 0, 2'b10, 4'hA, 0)));
    tbl.push_back(mk(0, 0, 2'b00, 4'h0, 4'd0, 0, 0, pk(1, 0, 0, 2'b10, 4'hA, 0)));
    // Long op=00 reps=15 keeps the queue from draining while four more fill it.
    tbl.push_back(mk(1, 0, 2'b00, 4'h0, 4'd15, 0, 0, pk(1, 0, 0, 2'b10, 4'hA, 0)));
    tbl.push_back(mk(1, 0, 2'b01, 4'h0, 4'd0, 0, 0, pk(1, 1, 0, 2'b00, 4'hA, 0)));
    tbl.push_back(mk(1, 0, 2'b10, 4'h0, 4'd0, 0, 0, pk(1, 1, 0, 2'b00, 4'hA, 0)));
    tbl.push_back(mk(1, 0, 2'b11, 4'h0, 4'd0, 0, 0, pk(1, 1, 0, 2'b00, 4'hA, 0)));
    tbl.push_back(mk(1, 0, 2'b01, 4'h0, 4'd1, 0, 0, pk(0, 1, 0, 2'b00, 4'hA, 0)));
    for (int i = 0; i < 12; i++)
      tbl.push_back(mk(1, 0, 2'b10, 4'h0, 4'd0, 0, 0, pk(0, 1, 0, 2'b00, 4'hA, 0)));
    tbl.push_back(mk(1, 0, 2'b10, 4'h0, 4'd0, 0, 0, pk(1, 1, 0, 2'b01, 4'hA, 0)));
    tbl.push_back(mk(1, 0, 2'b10, 4'h0, 4'd0, 0, 0, pk(1, 1, 0, 2'b10, 4'hA, 0)));
    tbl.push_back(mk(0, 0, 2'b00, 4'h0, 4'd0, 0, 0, pk(1, 1, 0, 2'b11, 4'hA, 0)));
    tbl.push_back(mk(0, 0, 2'b00, 4'h0, 4'd0, 0, 0, pk(1, 1, 0, 2'b01, 4'hA, 0)));
    tbl.push_back(mk(0, 0, 2'b00, 4'h0, 4'd0, 0, 0, pk(1, 1, 0, 2'b01, 4'hA, 0)));
    tbl.push_back(mk(0, 0, 2'b00, 4'h0, 4'd0, 0, 0, pk(1, 1, 0, 2'b10, 4'hA, 0)));
    tbl.push_back(mk(0, 0, 2'b00, 4'h0, 4'd0, 0, 0, pk(1, 0, 0, 2'b10, 4'hA, 0)));

    reset = 1'b1;
    cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = 2'b00; cmd_value = 4'h0; cmd_reps = 4'h0;
    GAMEOVER = 1'b0; game_reset = 1'b0;
    #12;
    chk("reset_state", pk(1, 0, 0, 2'b00, 4'h0, 0));
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].vld, tbl[i].ld, tbl[i].op, tbl[i].val, tbl[i].reps, tbl[i].go, tbl[i].gr);
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // One active plus three queued, then GAMEOVER with no handshake: four dropped.
    step(1, 0, 2'b00, 4'h0, 4'd15, 0, 0);
    step(1, 0, 2'b01, 4'h0, 4'd0, 0, 0);
    step(1, 0, 2'b10, 4'h0, 4'd0, 0, 0);
    step(1, 0, 2'b11, 4'h0, 4'd0, 0, 0);
    chk("pre_gameover", pk(1, 1, 0, 2'b00, 4'hA, 0));
    step(0, 0, 2'b00, 4'h0, 4'd0, 1, 0);
    chk("gameover_drop4", pk(0, 0, 0, 2'b00, 4'hA, 4));
    idle();
    chk("flush_wait", pk(0, 0, 0, 2'b00, 4'hA, 4));
    step(0, 0, 2'b00, 4'h0, 4'd0, 0, 1);
    chk("flush_grst_hi", pk(0, 0, 0, 2'b00, 4'hA, 4));
    idle();
    chk("flush_exit", pk(1, 0, 0, 2'b00, 4'hA, 4));
    idle();
    chk("fifo_empty_after_flush", pk(1, 0, 0, 2'b00, 4'hA, 4));

    // A handshake on the GAMEOVER edge is counted as dropped too.
    step(1, 0, 2'b01, 4'h0, 4'd0, 1, 0);
    chk("gameover_with_push", pk(0, 0, 0, 2'b00, 4'hA, 5));
    step(0, 0, 2'b00, 4'h0, 4'd0, 0, 1);
    idle();
    chk("flush2_exit", pk(1, 0, 0, 2'b00, 4'hA, 5));
    idle();
    chk("pushed_cmd_discarded", pk(1, 0, 0, 2'b00, 4'hA, 5));

    // Async reset between edges while applying a command.
    step(1, 0, 2'b11, 4'h0, 4'd5, 0, 0);
    idle();
    chk("apply_before_reset", pk(1, 1, 0, 2'b11, 4'hA, 5));
    #3 reset = 1'b1;
    #1;
    chk("async_reset_mid_apply", pk(1, 0, 0, 2'b00, 4'h0, 0));
    @(posedge clk);
    #1 reset = 1'b0;
    idle();
    chk("after_reset_idle", pk(1, 0, 0, 2'b00, 4'h0, 0));

    // Each round drops one active plus four queued; the count must stop at 255.
    exp_drop = 8'd0;
    for (int r = 0; r < 53; r++) begin
      step(1, 0, 2'b00, 4'h0, 4'd15, 0, 0);
      for (int k = 0; k < 4; k++) step(1, 0, 2'b01, 4'h0, 4'd0, 0, 0);
      step(0, 0, 2'b00, 4'h0, 4'd0, 1, 0);
      exp_drop = (int'(exp_drop) + 5 > 255) ? 8'd255 : exp_drop + 8'd5;
      chk($sformatf("sat_round%0d", r), pk(0, 0, 0, 2'b00, 4'h0, exp_drop));
      step(0, 0, 2'b00, 4'h0, 4'd0, 0, 1);
      idle();
    end
    chk("dropped_saturated", pk(1, 0, 0, 2'b00, 4'h0, 8'd255));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
